frame_buf_reader: RTL and testbench

- Read-side engine for the ISP frame buffer dual-port RAM.
- Drives the RAM's read port (addr_b/dout_b) and streams one stored frame out as a valid/ready pixel stream with SOF/EOL/EOF markers.
- Hides the RAM's one-cycle registered-address read latency behind a 2-entry skid FIFO.
- Sustains 1 pixel/clk when the downstream consumer is always ready.

---
 rtl/isp_fb_pkg.sv | 20 ++
 rtl/fb_skid_fifo2.sv | 70 +++++++
 rtl/frame_buf_reader.sv | 153 +++++++++++++++
 tb/tb_frame_buf_reader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_fb_pkg.sv
// rtl/isp_fb_pkg.sv - shared frame buffer geometry, reader FSM states and pixel sideband type
package isp_fb_pkg;

  localparam int FB_ADDR_WIDTH = 14;
  localparam int FB_IMG_W      = 88;
  localparam int FB_IMG_H      = 110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } fb_state_e;

  typedef struct packed {
    logic eof;
    logic eol;
    logic sof;
  } fb_sideband_t;

endpackage

// File: rtl/fb_skid_fifo2.sv
// rtl/fb_skid_fifo2.sv - two-entry skid FIFO with occupancy count and synchronous flush
module fb_skid_fifo2 #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = din;
          else                 tail_d = din;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Full: head advances to the tail slot and the new word takes its place.
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = din;
          end else begin
            head_d = din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign dout  = head_q;
  assign count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(!flush && push && !pop && count_q == 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(!flush && pop && count_q == 2'd0));

endmodule

// File: rtl/frame_buf_reader.sv
// rtl/frame_buf_reader.sv - streams one stored frame from the RAM read port as a pixel stream
module frame_buf_reader
  import isp_fb_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = FB_IMG_W,
  parameter int IMG_H      = FB_IMG_H
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] dout_b,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int EW = DATA_WIDTH + 3;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(IMG_W * IMG_H - 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  fb_state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0]    base_q, base_d;
  logic [ADDR_WIDTH-1:0]    idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]    addr_hold_q, addr_hold_d;
  logic [XW-1:0]            x_q, x_d;
  logic [YW-1:0]            y_q, y_d;
  fb_sideband_t             sb_q, sb_d;
  logic                     inflight_q, inflight_d;
  logic                     done_q, done_d;

  logic [1:0]               fifo_count;
  logic [EW-1:0]            fifo_head;
  fb_sideband_t             head_sb;
  logic                     pop, issue, flush;
  logic [2:0]               occ;
  logic [ADDR_WIDTH-1:0]    addr_issue;

  assign m_valid = (fifo_count != 2'd0);
  assign pop     = m_valid & m_ready;
  assign head_sb = fb_sideband_t'(fifo_head[EW-1:DATA_WIDTH]);
  assign flush   = abort && (state_q != IDLE);

  // Words already owed to the FIFO (stored + in flight) after this cycle's pop must stay below 2.
  assign occ        = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state_q == READ) && !abort && (occ < 3'd2);
  assign addr_issue = base_q + idx_q;
  assign addr_b     = issue ? addr_issue : addr_hold_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    idx_d       = idx_q;
    x_d         = x_q;
    y_d         = y_q;
    sb_d        = sb_q;
    done_d      = 1'b0;
    addr_hold_d = issue ? addr_issue : addr_hold_q;
    inflight_d  = issue;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = READ;
          base_d  = base_addr;
          idx_d   = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      READ: begin
        if (abort) begin
          state_d = IDLE;
        end else if (issue) begin
          idx_d    = idx_q + 1'b1;
          sb_d.sof = (x_q == '0) && (y_q == '0);
          sb_d.eol = (x_q == X_LAST);
          sb_d.eof = (x_q == X_LAST) && (y_q == Y_LAST);
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (idx_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pop && head_sb.eof) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      idx_q       <= '0;
      addr_hold_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      sb_q        <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      addr_hold_q <= addr_hold_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sb_q        <= sb_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
    end
  end

  fb_skid_fifo2 #(.W(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (inflight_q),
    .din   ({sb_q, dout_b}),
    .pop   (pop),
    .dout  (fifo_head),
    .count (fifo_count)
  );

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign m_data = m_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
  assign m_sof  = m_valid & head_sb.sof;
  assign m_eol  = m_valid & head_sb.eol;
  assign m_eof  = m_valid & head_sb.eof;

endmodule

// File: tb/tb_frame_buf_reader.sv
// tb/tb_frame_buf_reader.sv - scoreboard and vector-table bench for frame_buf_reader
module tb_frame_buf_reader;

  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int W     = 88;
  localparam int H     = 110;
  localparam int TOTAL = W * H;

  typedef struct {
    logic [DW-1:0] data;
    logic          sof;
    logic          eol;
    logic          eof;
  } pixel_t;

  typedef struct {
    logic          start;
    logic          abort;
    logic [AW-1:0] base;
    logic          exp_busy;
    logic          exp_valid;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_done;
  } vec_t;

  logic          clk, rst, start, abort, busy, done, m_valid, m_ready;
  logic          m_sof, m_eol, m_eof;
  logic [AW-1:0] base_addr, addr_b;
  logic [DW-1:0] dout_b, m_data;
  logic [DW-1:0] ram [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pixel_t        exp_q[$];
  int            frame_acc, done_cnt, start_cyc, first_valid_cyc, last_hs_cyc, eof_cyc;
  logic          done_seen, chk_proto, chk_ahead, stall_q;
  logic [31:0]   stall_pix;
  logic [AW-1:0] base_cur;
  vec_t          vecs[10];

  frame_buf_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .busy(busy), .done(done), .addr_b(addr_b), .dout_b(dout_b),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) dout_b <= ram[addr_b];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic mon();
    pixel_t e;
    logic   pop_now;
    logic [AW-1:0] d;
    pop_now = m_valid && m_ready;
    if (chk_proto && stall_q) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_pixel", 32'({m_data, m_sof, m_eol, m_eof}), stall_pix);
    end
    stall_q   = m_valid && !m_ready;
    stall_pix = 32'({m_data, m_sof, m_eol, m_eof});
    if (chk_ahead && busy) begin
      d = addr_b - base_cur;
      chk("addr_ahead", 32'(int'(d) <= frame_acc + int'(pop_now) + 1), 32'd1);
    end
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (pop_now) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pixel", 32'(frame_acc), 32'hffffffff);
      end else begin
        e = exp_q.pop_front();
        chk("pixel", 32'({m_data, m_sof, m_eol, m_eof}), 32'({e.data, e.sof, e.eol, e.eof}));
      end
      last_hs_cyc = cyc;
      if (m_eof) eof_cyc = cyc;
      frame_acc++;
    end
    if (done) begin
      done_cnt++;
      done_seen = 1'b1;
      chk("done_after_eof", 32'(cyc), 32'(eof_cyc + 1));
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    pixel_t p;
    for (int k = 0; k < TOTAL; k++) begin
      p.data = ram[AW'(int'(b) + k)];
      p.sof  = (k == 0);
      p.eol  = (k % W == W - 1);
      p.eof  = (k == TOTAL - 1);
      exp_q.push_back(p);
    end
    frame_acc = 0; base_cur = b; done_seen = 1'b0;
    first_valid_cyc = -1; start_cyc = cyc;
    start = 1'b1; base_addr = b;
    step();
    start = 1'b0;
  endtask

  task automatic run_frame(input bit rnd, input int bound, input bit timing);
    int n = 0;
    int dc0 = done_cnt;
    while (!done_seen && n < bound) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    m_ready = 1'b1;
    step();
    step();
    chk("frame_done_seen", 32'(done_seen), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_once", 32'(done_cnt - dc0), 32'd1);
    if (timing) begin
      chk("first_latency", 32'(first_valid_cyc - start_cyc), 32'd3);
      chk("no_bubbles", 32'(last_hs_cyc - first_valid_cyc), 32'(TOTAL - 1));
    end
  endtask

  initial begin
    int dc, n;
    for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
    vecs[0] = '{1'b1, 1'b0, 14'd100, 1'b0, 1'b0, 14'd0,   8'd0,   1'b0};
    vecs[1] = '{1'b0, 1'b0, 14'd0,   1'b1, 1'b0, 14'd100, 8'd0,   1'b0};
    vecs[2] = '{1'b0, 1'b0, 14'd0,   1'b1, 1'b0, 14'd101, 8'd0,   1'b0};
    vecs[3] = '{1'b0, 1'b0, 14'd0,   1'b1, 1'b1, 14'd101, 8'd100, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 14'd0,   1'b1, 1'b1, 14'd101, 8'd100, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 14'd0,   1'b1, 1'b1, 14'd101, 8'd100, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 14'd0,   1'b0, 1'b0, 14'd101, 8'd0,   1'b0};
    vecs[7] = '{1'b0, 1'b1, 14'd0,   1'b0, 1'b0, 14'd101, 8'd0,   1'b0};
    vecs[8] = '{1'b1, 1'b1, 14'd555, 1'b0, 1'b0, 14'd101, 8'd0,   1'b0};
    vecs[9] = '{1'b0, 1'b0, 14'd0,   1'b0, 1'b0, 14'd101, 8'd0,   1'b0};

    rst = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; m_ready = 1'b0;
    chk_proto = 1'b0; chk_ahead = 1'b0; stall_q = 1'b0; stall_pix = '0;
    done_cnt = 0; frame_acc = 0; eof_cyc = -10; last_hs_cyc = 0;
    first_valid_cyc = -1; start_cyc = 0; done_seen = 1'b0; base_cur = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_outputs", 32'({busy, done, m_valid, m_sof, m_eol, m_eof, m_data, addr_b}), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Latency, stall, abort and start/abort collision, cycle by cycle.
    for (int r = 0; r < 10; r++) begin
      start = vecs[r].start; abort = vecs[r].abort; base_addr = vecs[r].base;
      @(negedge clk);
      chk($sformatf("vec%0d_busy", r), 32'(busy), 32'(vecs[r].exp_busy));
      chk($sformatf("vec%0d_valid", r), 32'(m_valid), 32'(vecs[r].exp_valid));
      chk($sformatf("vec%0d_addr", r), 32'(addr_b), 32'(vecs[r].exp_addr));
      chk($sformatf("vec%0d_done", r), 32'(done), 32'(vecs[r].exp_done));
      if (vecs[r].exp_valid) chk($sformatf("vec%0d_data", r), 32'(m_data), 32'(vecs[r].exp_data));
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0;

    // Full frame, always ready.
    do_start(14'd0);
    run_frame(1'b0, TOTAL + 50, 1'b1);

    // Random backpressure with hold and issue-ahead checks.
    chk_proto = 1'b1; chk_ahead = 1'b1;
    do_start(14'd3000);
    run_frame(1'b1, 4 * TOTAL, 1'b0);
    chk_ahead = 1'b0;

    // Stalled consumer right after start.
    m_ready = 1'b0;
    do_start(14'd5);
    for (int i = 0; i < 20; i++) step();
    chk("stall_valid", 32'(m_valid), 32'd1);
    chk("stall_data", 32'(m_data), 32'd5);
    chk("stall_sof", 32'(m_sof), 32'd1);
    chk("stall_addr", 32'(addr_b), 32'd6);
    run_frame(1'b0, TOTAL + 50, 1'b0);
    chk_proto = 1'b0; stall_q = 1'b0;

    // Address wrap at the top of the RAM.
    m_ready = 1'b1;
    do_start(14'd16380);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("wrap_addr%0d", i), 32'(addr_b), 32'((16380 + i) % (1 << AW)));
      step();
    end
    n = 0;
    while (frame_acc < 8 && n < 50) begin step(); n++; end
    chk("wrap_acc", 32'(frame_acc >= 8), 32'd1);
    abort = 1'b1; step(); abort = 1'b0;
    exp_q.delete();

    // Abort after 100 accepted pixels, then a fresh frame.
    do_start(14'd0);
    n = 0;
    while (frame_acc < 100 && n < 500) begin step(); n++; end
    chk("abort_reach100", 32'(frame_acc >= 100), 32'd1);
    dc = done_cnt;
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_valid", 32'(m_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 10; i++) step();
    chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
    do_start(14'd0);
    run_frame(1'b0, TOTAL + 50, 1'b1);

    // Ignored start while busy, then asynchronous reset mid-frame.
    do_start(14'd0);
    for (int i = 0; i < 20; i++) step();
    start = 1'b1; base_addr = 14'd1000; step(); start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("pre_rst_valid", 32'(m_valid), 32'd1);
    dc = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("midrst_outputs", 32'({busy, done, m_valid, m_sof, m_eol, m_eof, m_data, addr_b}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) step();
    chk("rst_no_done", 32'(done_cnt - dc), 32'd0);
    chk("rst_idle", 32'(busy), 32'd0);
    do_start(14'd7);
    run_frame(1'b0, TOTAL + 50, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
